// File: rtl/paint_pkg.sv
// Shared types for the paint controller: FSM states, stamp sources and
// the brush-width helper used to size the brush register.
package paint_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    DISPATCH,
    CURSOR,
    PAL_CURSOR,
    PAL_WAIT,
    CHANGE_COLOR,
    STAMP
  } state_t;

  // Which value a stamp writes: the current paint color or the background.
  typedef enum logic {
    SRC_COLOR = 1'b0,
    SRC_BG    = 1'b1
  } stamp_src_t;

  function automatic int brush_w(input int bmax);
    return $clog2(bmax + 1);
  endfunction

endpackage

// File: rtl/brush_scan.sv
// dx/dy raster counter for the brush stamp. The target/clip outputs describe
// the position the counter moves to on this edge, so the caller can register it.
module brush_scan #(
  parameter int COORD_W = 8,
  parameter int BW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic [BW-1:0]      brush,
  input  logic [COORD_W-1:0] base_x,
  input  logic [COORD_W-1:0] base_y,
  output logic [COORD_W-1:0] nxt_x,
  output logic [COORD_W-1:0] nxt_y,
  output logic               clip,
  output logic               last
);

  logic [BW-1:0]    dx, dy, dx_n, dy_n;
  logic [COORD_W:0] sum_x, sum_y;

  always_comb begin
    dx_n = dx;
    dy_n = dy;
    if (start) begin
      dx_n = '0;
      dy_n = '0;
    end else if (step) begin
      if (dx == brush - BW'(1)) begin
        dx_n = '0;
        dy_n = dy + BW'(1);
      end else begin
        dx_n = dx + BW'(1);
      end
    end
  end

  // One extra bit so a carry past the canvas edge shows up as clip.
  always_comb begin
    sum_x = {1'b0, base_x} + (COORD_W+1)'(dx_n);
    sum_y = {1'b0, base_y} + (COORD_W+1)'(dy_n);
    nxt_x = sum_x[COORD_W-1:0];
    nxt_y = sum_y[COORD_W-1:0];
    clip  = sum_x[COORD_W] | sum_y[COORD_W];
    last  = (dx == brush - BW'(1)) && (dy == brush - BW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= dx_n;
      dy <= dy_n;
    end
  end

endmodule

// File: rtl/paint_ctrl_multi.sv
// Painting controller: cursor redraw, palette pick, brush paint/erase and
// brush resize. wr_valid/wr_ready: a beat transfers on the edge where both are high.
module paint_ctrl_multi
  import paint_pkg::*;
#(
  parameter int COORD_W   = 8,
  parameter int COLOR_W   = 8,
  parameter int BRUSH_MAX = 4,
  parameter int BG_COLOR  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init,
  input  logic [COORD_W-1:0]            in_x,
  input  logic [COORD_W-1:0]            in_y,
  input  logic                          key_pal,
  input  logic                          key_enter,
  input  logic                          key_erase,
  input  logic                          key_bup,
  input  logic                          key_bdn,
  input  logic                          pal_enter,
  input  logic [COLOR_W-1:0]            cursor_px,
  input  logic [COLOR_W-1:0]            pal_px,
  input  logic                          cursor_done,
  input  logic                          pal_done,
  input  logic                          wr_ready,
  output logic                          cursor_start,
  output logic                          pal_start,
  output logic                          pal_active,
  output logic                          wr_valid,
  output logic [COORD_W-1:0]            wr_x,
  output logic [COORD_W-1:0]            wr_y,
  output logic [COLOR_W-1:0]            wr_data,
  output logic [COLOR_W-1:0]            color,
  output logic [brush_w(BRUSH_MAX)-1:0] brush,
  output logic                          busy,
  output state_t                        state_dbg
);

  localparam int BW = brush_w(BRUSH_MAX);
  localparam int HW = COLOR_W / 2;

  state_t             state, state_n;
  stamp_src_t         src;
  logic [COORD_W-1:0] base_x, base_y;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               scan_start, scan_step, scan_clip, scan_last;
  logic [COLOR_W-1:0] stamp_data;

  brush_scan #(.COORD_W(COORD_W), .BW(BW)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .start  (scan_start),
    .step   (scan_step),
    .brush  (brush),
    .base_x (base_x),
    .base_y (base_y),
    .nxt_x  (scan_x),
    .nxt_y  (scan_y),
    .clip   (scan_clip),
    .last   (scan_last)
  );

  always_comb begin
    state_n    = state;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    case (state)
      IDLE:         if (init) state_n = SAMPLE;
      SAMPLE:       state_n = DISPATCH;
      DISPATCH: begin
        if (key_pal) begin
          state_n = PAL_CURSOR;
        end else if (key_enter || key_erase) begin
          state_n    = STAMP;
          scan_start = 1'b1;
        end else begin
          state_n = CURSOR;
        end
      end
      CURSOR:       if (cursor_done) state_n = SAMPLE;
      PAL_CURSOR:   if (pal_done) state_n = PAL_WAIT;
      PAL_WAIT:     state_n = pal_enter ? CHANGE_COLOR : PAL_CURSOR;
      CHANGE_COLOR: state_n = SAMPLE;
      STAMP: begin
        // Skipped (clipped) targets have wr_valid low and advance at once.
        if (!wr_valid || wr_ready) begin
          if (scan_last) state_n = SAMPLE;
          else           scan_step = 1'b1;
        end
      end
      default:      state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    src = key_enter ? SRC_COLOR : SRC_BG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_x     <= '0;
      base_y     <= '0;
      color      <= COLOR_W'(BG_COLOR);
      brush      <= BW'(1);
      wr_valid   <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      stamp_data <= '0;
    end else begin
      if (state == SAMPLE) begin
        base_x <= in_x;
        base_y <= in_y;
      end
      if (state == DISPATCH && !key_pal && !key_enter && !key_erase) begin
        if (key_bup && !key_bdn && brush < BW'(BRUSH_MAX))
          brush <= brush + BW'(1);
        else if (key_bdn && !key_bup && brush > BW'(1))
          brush <= brush - BW'(1);
      end
      if (state == CHANGE_COLOR)
        color <= {in_x[HW-1:0], in_y[HW-1:0]};
      if (scan_start) begin
        wr_valid   <= !scan_clip;
        wr_x       <= scan_x;
        wr_y       <= scan_y;
        stamp_data <= (src == SRC_COLOR) ? color : COLOR_W'(BG_COLOR);
      end else if (scan_step) begin
        wr_valid <= !scan_clip;
        wr_x     <= scan_x;
        wr_y     <= scan_y;
      end else if (state == STAMP && state_n != STAMP) begin
        wr_valid <= 1'b0;
      end
      if (state == CURSOR) begin
        wr_x <= in_x;
        wr_y <= in_y;
      end
    end
  end

  always_comb begin
    case (state)
      CURSOR:     wr_data = cursor_px;
      PAL_CURSOR: wr_data = pal_px;
      default:    wr_data = stamp_data;
    endcase
  end

  assign cursor_start = (state == CURSOR);
  assign pal_start    = (state == PAL_CURSOR);
  assign pal_active   = (state == PAL_CURSOR) || (state == PAL_WAIT);
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_paint_ctrl_multi.sv
// Bench for paint_ctrl_multi: directed palette/brush/stamp scenarios plus a few
// random clipped stamps, with written beats checked against an expected queue.
module tb_paint_ctrl_multi;
  import paint_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic [7:0] in_x = '0, in_y = '0;
  logic       key_pal = 1'b0, key_enter = 1'b0, key_erase = 1'b0;
  logic       key_bup = 1'b0, key_bdn = 1'b0;
  logic       pal_enter = 1'b0;
  logic [7:0] cursor_px = 8'hC1, pal_px = 8'hA7;
  logic       cursor_done = 1'b0, pal_done = 1'b0;
  logic       wr_ready = 1'b1;
  logic       cursor_start, pal_start, pal_active, wr_valid, busy;
  logic [7:0] wr_x, wr_y, wr_data, color;
  logic [2:0] brush;
  state_t     state_dbg;

  paint_ctrl_multi dut (
    .clk(clk), .rst(rst), .init(init), .in_x(in_x), .in_y(in_y),
    .key_pal(key_pal), .key_enter(key_enter), .key_erase(key_erase),
    .key_bup(key_bup), .key_bdn(key_bdn), .pal_enter(pal_enter),
    .cursor_px(cursor_px), .pal_px(pal_px), .cursor_done(cursor_done),
    .pal_done(pal_done), .wr_ready(wr_ready), .cursor_start(cursor_start),
    .pal_start(pal_start), .pal_active(pal_active), .wr_valid(wr_valid),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .color(color),
    .brush(brush), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_writes = 0;
  int stamp_cycles = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_t s, input int budget);
    int n = 0;
    while (state_dbg != s && n < budget) begin
      tick();
      n++;
    end
    check("wait_state", 32'(state_dbg), 32'(s));
  endtask

  // Starts from CURSOR; keys = {pal, enter, erase, bup, bdn}. Returns in the dispatched state.
  task automatic cmd(input logic [4:0] keys, input logic [7:0] x, input logic [7:0] y);
    in_x = x;
    in_y = y;
    {key_pal, key_enter, key_erase, key_bup, key_bdn} = keys;
    cursor_done = 1'b1;
    tick();
    cursor_done = 1'b0;
    tick();
    tick();
    {key_pal, key_enter, key_erase, key_bup, key_bdn} = '0;
  endtask

  task automatic push_stamp(input int x, input int y, input int b, input logic [7:0] d);
    for (int dy = 0; dy < b; dy++)
      for (int dx = 0; dx < b; dx++)
        if (x + dx < 256 && y + dy < 256)
          exp_q.push_back({8'(x + dx), 8'(y + dy), d});
  endtask

  // Beat monitor and hold checker, sampled on the falling edge.
  logic       prev_stall = 1'b0;
  logic [23:0] prev_beat = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (state_dbg == STAMP) stamp_cycles++;
      if (prev_stall) check("hold", {7'd0, wr_valid, wr_x, wr_y, wr_data}, {8'd1, prev_beat});
      if (wr_valid && wr_ready) begin
        n_writes++;
        if (exp_q.size() == 0) check("beat_unexpected", {wr_x, wr_y, wr_data}, 24'hFFFFFF);
        else check("beat", {wr_x, wr_y, wr_data}, exp_q.pop_front());
      end
      prev_stall = wr_valid && !wr_ready;
      prev_beat  = {wr_x, wr_y, wr_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int rx, ry;
    // Reset
    tick();
    tick();
    check("rst_color", color, 8'h00);
    check("rst_brush", brush, 3'd1);
    check("rst_valid", wr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wrxy", {wr_x, wr_y, wr_data}, 24'h0);
    rst = 1'b0;

    // Palette: one round without confirm, then confirm at (3,5)
    init = 1'b1;
    key_pal = 1'b1;
    wait_state(PAL_CURSOR, 10);
    init = 1'b0;
    key_pal = 1'b0;
    check("pal_start", {pal_start, pal_active, busy}, 3'b111);
    check("pal_mux", wr_data, 8'hA7);
    pal_done = 1'b1;
    tick();
    pal_done = 1'b0;
    check("pal_wait", 32'(state_dbg), 32'(PAL_WAIT));
    tick();
    check("pal_retry", 32'(state_dbg), 32'(PAL_CURSOR));
    in_x = 8'h03;
    in_y = 8'h05;
    pal_done = 1'b1;
    tick();
    pal_done = 1'b0;
    pal_enter = 1'b1;
    tick();
    pal_enter = 1'b0;
    tick();
    check("pal_color", color, 8'h35);
    wait_state(CURSOR, 10);
    check("cur_start", {cursor_start, pal_active}, 2'b10);
    check("cur_mux", wr_data, 8'hC1);

    // Brush up then paint 2x2 at (4,4)
    cmd(5'b00010, 8'd0, 8'd0);
    check("brush_up", brush, 3'd2);
    wait_state(CURSOR, 10);
    push_stamp(4, 4, 2, 8'h35);
    stamp_cycles = 0;
    n_writes = 0;
    cmd(5'b01000, 8'd4, 8'd4);
    wait_state(CURSOR, 50);
    check("paint_writes", n_writes, 4);
    check("paint_cycles", stamp_cycles, 4);
    check("paint_q", exp_q.size(), 0);

    // Erase at the far corner: three targets clipped
    push_stamp(255, 255, 2, 8'h00);
    stamp_cycles = 0;
    n_writes = 0;
    cmd(5'b00100, 8'd255, 8'd255);
    wait_state(CURSOR, 50);
    check("clip_writes", n_writes, 1);
    check("clip_cycles", stamp_cycles, 4);
    check("clip_q", exp_q.size(), 0);

    // Brush down to 1, then saturation at 1
    cmd(5'b00001, 8'd0, 8'd0);
    check("brush_dn", brush, 3'd1);
    wait_state(CURSOR, 10);
    cmd(5'b00001, 8'd0, 8'd0);
    check("brush_sat_lo", brush, 3'd1);
    wait_state(CURSOR, 10);

    // Backpressure: ready low for 3 stamp cycles
    wr_ready = 1'b0;
    push_stamp(10, 20, 1, 8'h35);
    stamp_cycles = 0;
    n_writes = 0;
    cmd(5'b01000, 8'd10, 8'd20);
    check("bp_state", 32'(state_dbg), 32'(STAMP));
    for (int i = 0; i < 3; i++) begin
      check("bp_beat", {7'd0, wr_valid, wr_x, wr_y, wr_data}, {8'd1, 8'd10, 8'd20, 8'h35});
      if (i < 2) tick();
    end
    tick();
    wr_ready = 1'b1;
    wait_state(CURSOR, 20);
    check("bp_writes", n_writes, 1);
    check("bp_cycles", stamp_cycles, 4);

    // Both keys: unchanged; bup to saturation at 4
    cmd(5'b00011, 8'd0, 8'd0);
    check("brush_both", brush, 3'd1);
    for (int i = 0; i < 4; i++) begin
      wait_state(CURSOR, 10);
      cmd(5'b00010, 8'd0, 8'd0);
    end
    check("brush_sat_hi", brush, 3'd4);
    wait_state(CURSOR, 10);

    // Random stamps near the right edge with random backpressure
    for (int k = 0; k < 3; k++) begin
      rx = $urandom_range(250, 255);
      ry = $urandom_range(0, 255);
      push_stamp(rx, ry, 4, (k == 1) ? 8'h00 : 8'h35);
      cmd((k == 1) ? 5'b00100 : 5'b01000, 8'(rx), 8'(ry));
      for (int n = 0; n < 200 && state_dbg != CURSOR; n++) begin
        wr_ready = 1'($urandom_range(0, 1));
        tick();
      end
      wr_ready = 1'b1;
      check("rand_done", 32'(state_dbg), 32'(CURSOR));
      check("rand_q", exp_q.size(), 0);
    end

    // Reset abort mid-stamp at brush 4
    wr_ready = 1'b0;
    cmd(5'b01000, 8'd100, 8'd100);
    tick();
    check("abort_pre", {7'd0, wr_valid}, 8'd1);
    rst = 1'b1;
    tick();
    check("abort_valid", wr_valid, 1'b0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    wr_ready = 1'b1;
    tick();
    tick();
    check("abort_noreissue", {wr_valid, busy}, 2'b00);
    check("final_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
